// File: rtl/cpu_memory.sv
// cpu_memory: memory stage of a pipelined CPU.
//
// Accepts one request per new tag from execute. Non-memory requests pass the
// execute result through in one cycle. Misaligned loads/stores fault without
// touching the bus. Aligned loads/stores run a single bus transaction that
// stays on the bus until i_bus_ready, then return the (extended) load data.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_stall                   writeback cannot accept; blocks acceptance only
//   i_tag                     request tag; differs from o_tag => new request
//   i_inst_rd, i_rd           destination register and execute result
//   i_mem_read, i_mem_write   load / store
//   i_mem_width, i_mem_signed access width (1/2/4, else word), sign-extend load
//   i_mem_address, i_mem_wdata byte address, LSB-aligned store data
//   o_bus_*                   bus request, rw, word address, lanes, write data
//   i_bus_ready, i_bus_rdata  transaction complete, read data
//   o_tag, o_inst_rd, o_rd    completed request tag, destination, result
//   o_fault                   last completed request was misaligned
//   o_stall                   upstream must hold its inputs

`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module cpu_memory (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic [`TAG_SIZE-1:0] i_tag,
    input  logic [4:0]           i_inst_rd,
    input  logic [31:0]          i_rd,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [2:0]           i_mem_width,
    input  logic                 i_mem_signed,
    input  logic [31:0]          i_mem_address,
    input  logic [31:0]          i_mem_wdata,
    output logic                 o_bus_request,
    output logic                 o_bus_rw,
    output logic [31:0]          o_bus_address,
    output logic [3:0]           o_bus_byte_enable,
    output logic [31:0]          o_bus_wdata,
    input  logic                 i_bus_ready,
    input  logic [31:0]          i_bus_rdata,
    output logic [`TAG_SIZE-1:0] o_tag,
    output logic [4:0]           o_inst_rd,
    output logic [31:0]          o_rd,
    output logic                 o_fault,
    output logic                 o_stall
);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                 r_bus_request;
    logic                 r_bus_rw;
    logic [31:0]          r_bus_address;
    logic [3:0]           r_bus_byte_enable;
    logic [31:0]          r_bus_wdata;
    logic [`TAG_SIZE-1:0] r_tag;
    logic [4:0]           r_inst_rd;
    logic [31:0]          r_rd;
    logic                 r_fault;

    // Attributes of the in-flight access, captured at acceptance so the
    // completion does not depend on upstream holding its inputs.
    logic [`TAG_SIZE-1:0] r_ld_tag;
    logic [4:0]           r_ld_rd;
    logic [2:0]           r_ld_width;
    logic                 r_ld_signed;
    logic [1:0]           r_ld_offset;
    logic                 r_ld_write;

    logic        w_is_mem;
    logic        w_tag_new;
    logic        w_misaligned;
    logic        w_request;
    logic [3:0]  w_byte_enable;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign w_is_mem  = i_mem_read | i_mem_write;
    assign w_tag_new = (i_tag != r_tag);
    assign w_request = !i_stall && w_tag_new && (r_state == S_IDLE);

    // Any width other than 1 or 2 behaves as a word access.
    always_comb begin
        w_misaligned  = 1'b0;
        w_byte_enable = 4'b1111;
        w_wdata       = i_mem_wdata;
        case (i_mem_width)
            3'd1: begin
                w_misaligned  = 1'b0;
                w_byte_enable = 4'b0001 << i_mem_address[1:0];
                w_wdata       = {24'd0, i_mem_wdata[7:0]} << {i_mem_address[1:0], 3'b000};
            end
            3'd2: begin
                w_misaligned  = i_mem_address[0];
                w_byte_enable = 4'b0011 << {i_mem_address[1], 1'b0};
                w_wdata       = {16'd0, i_mem_wdata[15:0]} << {i_mem_address[1], 4'b0000};
            end
            default: begin
                w_misaligned  = (i_mem_address[1:0] != 2'b00);
                w_byte_enable = 4'b1111;
                w_wdata       = i_mem_wdata;
            end
        endcase
    end

    assign w_shifted = i_bus_rdata >> {r_ld_offset, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_ld_width)
            3'd1:    w_load_data = {{24{r_ld_signed & w_shifted[7]}}, w_shifted[7:0]};
            3'd2:    w_load_data = {{16{r_ld_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall = w_tag_new && w_is_mem && !w_misaligned;
                if (w_request && w_is_mem && !w_misaligned)
                    w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                o_stall = 1'b1;
                if (i_bus_ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bus_request     <= 1'b0;
            r_bus_rw          <= 1'b0;
            r_bus_address     <= '0;
            r_bus_byte_enable <= '0;
            r_bus_wdata       <= '0;
            r_tag             <= '0;
            r_inst_rd         <= '0;
            r_rd              <= '0;
            r_fault           <= 1'b0;
            r_ld_tag          <= '0;
            r_ld_rd           <= '0;
            r_ld_width        <= '0;
            r_ld_signed       <= 1'b0;
            r_ld_offset       <= '0;
            r_ld_write        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        if (!w_is_mem) begin
                            r_tag     <= i_tag;
                            r_inst_rd <= i_inst_rd;
                            r_rd      <= i_rd;
                            r_fault   <= 1'b0;
                        end else if (w_misaligned) begin
                            r_tag     <= i_tag;
                            r_inst_rd <= '0;
                            r_fault   <= 1'b1;
                        end else begin
                            // A request flagged both read and write is a store.
                            r_bus_request     <= 1'b1;
                            r_bus_rw          <= i_mem_write;
                            r_bus_address     <= {i_mem_address[31:2], 2'b00};
                            r_bus_byte_enable <= w_byte_enable;
                            r_bus_wdata       <= w_wdata;
                            r_ld_tag          <= i_tag;
                            r_ld_rd           <= i_inst_rd;
                            r_ld_width        <= i_mem_width;
                            r_ld_signed       <= i_mem_signed;
                            r_ld_offset       <= i_mem_address[1:0];
                            r_ld_write        <= i_mem_write;
                        end
                    end
                end
                S_ACCESS: begin
                    if (i_bus_ready) begin
                        r_bus_request <= 1'b0;
                        r_tag         <= r_ld_tag;
                        r_fault       <= 1'b0;
                        if (r_ld_write) begin
                            r_inst_rd <= '0;
                        end else begin
                            r_inst_rd <= r_ld_rd;
                            r_rd      <= w_load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_bus_request     = r_bus_request;
    assign o_bus_rw          = r_bus_rw;
    assign o_bus_address     = r_bus_address;
    assign o_bus_byte_enable = r_bus_byte_enable;
    assign o_bus_wdata       = r_bus_wdata;
    assign o_tag             = r_tag;
    assign o_inst_rd         = r_inst_rd;
    assign o_rd              = r_rd;
    assign o_fault           = r_fault;

endmodule

// File: tb/tb_cpu_memory.sv
// tb_cpu_memory: self-checking bench for cpu_memory.
// Table of request vectors plus hand-written sequences for stall, tag-equal,
// tag wrap-around and reset-during-access behaviour.

`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module tb_cpu_memory;

    localparam int TW = `TAG_SIZE;

    logic          i_clock;
    logic          i_reset;
    logic          i_stall;
    logic [TW-1:0] i_tag;
    logic [4:0]    i_inst_rd;
    logic [31:0]   i_rd;
    logic          i_mem_read;
    logic          i_mem_write;
    logic [2:0]    i_mem_width;
    logic          i_mem_signed;
    logic [31:0]   i_mem_address;
    logic [31:0]   i_mem_wdata;
    logic          o_bus_request;
    logic          o_bus_rw;
    logic [31:0]   o_bus_address;
    logic [3:0]    o_bus_byte_enable;
    logic [31:0]   o_bus_wdata;
    logic          i_bus_ready;
    logic [31:0]   i_bus_rdata;
    logic [TW-1:0] o_tag;
    logic [4:0]    o_inst_rd;
    logic [31:0]   o_rd;
    logic          o_fault;
    logic          o_stall;

    cpu_memory dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_stall          (i_stall),
        .i_tag            (i_tag),
        .i_inst_rd        (i_inst_rd),
        .i_rd             (i_rd),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_mem_width      (i_mem_width),
        .i_mem_signed     (i_mem_signed),
        .i_mem_address    (i_mem_address),
        .i_mem_wdata      (i_mem_wdata),
        .o_bus_request    (o_bus_request),
        .o_bus_rw         (o_bus_rw),
        .o_bus_address    (o_bus_address),
        .o_bus_byte_enable(o_bus_byte_enable),
        .o_bus_wdata      (o_bus_wdata),
        .i_bus_ready      (i_bus_ready),
        .i_bus_rdata      (i_bus_rdata),
        .o_tag            (o_tag),
        .o_inst_rd        (o_inst_rd),
        .o_rd             (o_rd),
        .o_fault          (o_fault),
        .o_stall          (o_stall)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [2:0]  width;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_in;
        logic [31:0] rdata;
        logic [4:0]  inst;
        int          lat;
        logic        x_bus;
        logic [3:0]  x_be;
        logic [31:0] x_lanes;
        logic [31:0] x_wdata;
        logic        x_keep;
        logic [31:0] x_rd;
        logic [4:0]  x_inst;
        logic        x_fault;
    } vec_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   rd;
        logic [4:0]    inst;
        logic          fault;
    } exp_t;

    exp_t          sb[$];
    logic [TW-1:0] tb_tag;
    logic [31:0]   model_rd;

    function automatic vec_t mk(
        input logic r, input logic w, input logic [2:0] wd, input logic s,
        input logic [31:0] a, input logic [31:0] wdat, input logic [31:0] rdin,
        input logic [31:0] rdat, input logic [4:0] inst, input int lat,
        input logic bus, input logic [3:0] be, input logic [31:0] lanes,
        input logic [31:0] xw, input logic keep, input logic [31:0] xrd,
        input logic [4:0] xinst, input logic fault);
        vec_t v;
        v.rd_op = r;      v.wr_op = w;      v.width = wd;    v.sgn = s;
        v.addr = a;       v.wdata = wdat;   v.rd_in = rdin;  v.rdata = rdat;
        v.inst = inst;    v.lat = lat;      v.x_bus = bus;   v.x_be = be;
        v.x_lanes = lanes; v.x_wdata = xw;  v.x_keep = keep; v.x_rd = xrd;
        v.x_inst = xinst; v.x_fault = fault;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        @(negedge i_clock);
        i_mem_read    = v.rd_op;
        i_mem_write   = v.wr_op;
        i_mem_width   = v.width;
        i_mem_signed  = v.sgn;
        i_mem_address = v.addr;
        i_mem_wdata   = v.wdata;
        i_rd          = v.rd_in;
        i_inst_rd     = v.inst;
        i_stall       = 1'b0;
        tb_tag        = tb_tag + 1'b1;
        i_tag         = tb_tag;
        if (!v.x_keep)
            model_rd = v.x_rd;
        e.tag = tb_tag; e.rd = model_rd; e.inst = v.x_inst; e.fault = v.x_fault;
        sb.push_back(e);
        #1 chk($sformatf("v%0d_stall_in", idx), 32'(o_stall), 32'(v.x_bus));
        @(negedge i_clock);
        chk($sformatf("v%0d_bus_req", idx), 32'(o_bus_request), 32'(v.x_bus));
        if (v.x_bus) begin
            chk($sformatf("v%0d_rw", idx), 32'(o_bus_rw), 32'(v.wr_op));
            chk($sformatf("v%0d_addr", idx), o_bus_address, v.addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_be", idx), 32'(o_bus_byte_enable), 32'(v.x_be));
            if (v.wr_op)
                chk($sformatf("v%0d_wdata", idx), o_bus_wdata & v.x_lanes, v.x_wdata);
            for (int c = 1; c < v.lat; c++) @(negedge i_clock);
            chk($sformatf("v%0d_held_req", idx), 32'(o_bus_request), 32'd1);
            chk($sformatf("v%0d_held_stall", idx), 32'(o_stall), 32'd1);
            chk($sformatf("v%0d_tag_pending", idx), 32'(o_tag != tb_tag), 32'd1);
            i_bus_ready = 1'b1;
            i_bus_rdata = v.rdata;
            @(negedge i_clock);
            i_bus_ready = 1'b0;
            i_bus_rdata = 32'hA5A5_A5A5;
            chk($sformatf("v%0d_req_drop", idx), 32'(o_bus_request), 32'd0);
        end
        for (int k = 0; k < 8 && o_tag != tb_tag; k++) @(negedge i_clock);
        chk($sformatf("v%0d_done_tag", idx), 32'(o_tag), 32'(tb_tag));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("v%0d_rd", idx), o_rd, e.rd);
            chk($sformatf("v%0d_inst_rd", idx), 32'(o_inst_rd), 32'(e.inst));
            chk($sformatf("v%0d_fault", idx), 32'(o_fault), 32'(e.fault));
        end
        chk($sformatf("v%0d_stall_after", idx), 32'(o_stall), 32'd0);
    endtask

    vec_t vt[14];
    vec_t wrap_v;

    initial begin
        // r  w  wd    s  addr          wdata          rd_in          rdata         inst lat bus be       lanes          xwdata         keep xrd            xinst fault
        vt[0]  = mk(0, 0, 3'd4, 0, 32'h0000_0301, 32'h0,         32'h0000_1234, 32'h0,         5, 1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0000_1234, 5,  0);
        vt[1]  = mk(1, 0, 3'd1, 1, 32'h0000_0103, 32'h0,         32'hBAD0_0001, 32'h80AA_5511, 7, 3, 1, 4'b1000, 32'h0,         32'h0,         0, 32'hFFFF_FF80, 7,  0);
        vt[2]  = mk(0, 1, 3'd2, 0, 32'h0000_0202, 32'h5555_ABCD, 32'h0000_0099, 32'hFFFF_FFFF, 9, 2, 1, 4'b1100, 32'hFFFF_0000, 32'hABCD_0000, 1, 32'h0,         0,  0);
        vt[3]  = mk(1, 0, 3'd4, 0, 32'h0000_0301, 32'h0,         32'h0000_0077, 32'h0,         3, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0,         0,  1);
        vt[4]  = mk(1, 0, 3'd2, 0, 32'h0000_0012, 32'h0,         32'h0,         32'h8001_7FFF, 4, 1, 1, 4'b1100, 32'h0,         32'h0,         0, 32'h0000_8001, 4,  0);
        vt[5]  = mk(1, 0, 3'd2, 1, 32'h0000_0010, 32'h0,         32'h0,         32'h1234_F00D, 6, 2, 1, 4'b0011, 32'h0,         32'h0,         0, 32'hFFFF_F00D, 6,  0);
        vt[6]  = mk(1, 0, 3'd4, 1, 32'h0000_0020, 32'h0,         32'h0,         32'hDEAD_BEEF, 8, 1, 1, 4'b1111, 32'h0,         32'h0,         0, 32'hDEAD_BEEF, 8,  0);
        vt[7]  = mk(0, 1, 3'd1, 0, 32'h0000_0031, 32'h1234_5677, 32'h0,         32'h0,        10, 1, 1, 4'b0010, 32'h0000_FF00, 32'h0000_7700, 1, 32'h0,         0,  0);
        vt[8]  = mk(1, 0, 3'd3, 0, 32'h0000_0042, 32'h0,         32'h0,         32'h0,        11, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0,         0,  1);
        vt[9]  = mk(1, 0, 3'd0, 0, 32'h0000_0044, 32'h0,         32'h0,         32'h0102_0304,12, 2, 1, 4'b1111, 32'h0,         32'h0,         0, 32'h0102_0304, 12, 0);
        vt[10] = mk(1, 0, 3'd1, 0, 32'h0000_0052, 32'h0,         32'h0,         32'h00C3_0000,13, 1, 1, 4'b0100, 32'h0,         32'h0,         0, 32'h0000_00C3, 13, 0);
        vt[11] = mk(0, 1, 3'd2, 0, 32'h0000_0061, 32'h0000_1111, 32'h0,         32'h0,        14, 1, 0, 4'b0000, 32'h0,         32'h0,         1, 32'h0,         0,  1);
        vt[12] = mk(0, 1, 3'd4, 0, 32'h0000_0070, 32'hCAFE_F00D, 32'h0,         32'h0,        15, 1, 1, 4'b1111, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1, 32'h0,         0,  0);
        vt[13] = mk(0, 0, 3'd2, 0, 32'h0000_0000, 32'h0,         32'h0,         32'h0,        31, 1, 0, 4'b0000, 32'h0,         32'h0,         0, 32'h0,        31,  0);

        i_reset = 1'b1; i_stall = 1'b0; i_tag = '0; i_inst_rd = '0; i_rd = '0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_width = 3'd4; i_mem_signed = 1'b0;
        i_mem_address = '0; i_mem_wdata = '0; i_bus_ready = 1'b0; i_bus_rdata = '0;
        tb_tag = '0; model_rd = '0;

        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        chk("rst_bus_req", 32'(o_bus_request), 32'd0);
        chk("rst_rw", 32'(o_bus_rw), 32'd0);
        chk("rst_addr", o_bus_address, 32'd0);
        chk("rst_be", 32'(o_bus_byte_enable), 32'd0);
        chk("rst_wdata", o_bus_wdata, 32'd0);
        chk("rst_tag", 32'(o_tag), 32'd0);
        chk("rst_inst_rd", 32'(o_inst_rd), 32'd0);
        chk("rst_rd", o_rd, 32'd0);
        chk("rst_fault", 32'(o_fault), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

        // Tag equal to o_tag: nothing happens even with an aligned load presented.
        @(negedge i_clock);
        i_tag = tb_tag; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_width = 3'd4;
        i_mem_address = 32'h0000_0800; i_rd = 32'h5A5A_5A5A; i_inst_rd = 5'd20;
        #1 chk("same_tag_stall", 32'(o_stall), 32'd0);
        repeat (2) @(negedge i_clock);
        chk("same_tag_req", 32'(o_bus_request), 32'd0);
        chk("same_tag_rd", o_rd, model_rd);
        chk("same_tag_inst", 32'(o_inst_rd), 32'd31);

        // i_stall blocks acceptance but never pauses an access in progress.
        @(negedge i_clock);
        i_stall = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_width = 3'd4;
        i_mem_signed = 1'b0; i_mem_address = 32'h0000_0400; i_inst_rd = 5'd3;
        tb_tag = tb_tag + 1'b1; i_tag = tb_tag;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clock);
            chk($sformatf("stall_c%0d_req", c), 32'(o_bus_request), 32'd0);
            chk($sformatf("stall_c%0d_ostall", c), 32'(o_stall), 32'd1);
        end
        i_stall = 1'b0;
        @(negedge i_clock);
        chk("stall_accept_req", 32'(o_bus_request), 32'd1);
        chk("stall_accept_addr", o_bus_address, 32'h0000_0400);
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clock);
            chk($sformatf("stall_acc_c%0d_req", c), 32'(o_bus_request), 32'd1);
        end
        i_bus_ready = 1'b1; i_bus_rdata = 32'h0BAD_F00D;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        model_rd = 32'h0BAD_F00D;
        chk("stall_done_tag", 32'(o_tag), 32'(tb_tag));
        chk("stall_done_rd", o_rd, model_rd);
        chk("stall_done_inst", 32'(o_inst_rd), 32'd3);
        chk("stall_done_req", 32'(o_bus_request), 32'd0);
        i_stall = 1'b0;

        // Tag wrap-around: all-ones followed by zero are both new requests.
        tb_tag = '1;
        tb_tag = tb_tag - 1'b1;
        wrap_v = mk(0, 0, 3'd4, 0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0, 1, 1, 0, 4'b0000, 32'h0, 32'h0, 0, 32'h0000_00FF, 1, 0);
        run_vec(100, wrap_v);
        wrap_v = mk(0, 0, 3'd4, 0, 32'h0, 32'h0, 32'h0000_0100, 32'h0, 2, 1, 0, 4'b0000, 32'h0, 32'h0, 0, 32'h0000_0100, 2, 0);
        run_vec(101, wrap_v);
        chk("wrap_tag_zero", 32'(o_tag), 32'd0);

        // Reset in the middle of an access; a late ready must be ignored.
        @(negedge i_clock);
        i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_width = 3'd4;
        i_mem_address = 32'h0000_0500; i_inst_rd = 5'd9;
        tb_tag = tb_tag + 1'b1; i_tag = tb_tag;
        @(negedge i_clock);
        chk("rsta_req", 32'(o_bus_request), 32'd1);
        i_reset = 1'b1;
        @(negedge i_clock);
        chk("rsta_req_drop", 32'(o_bus_request), 32'd0);
        chk("rsta_tag", 32'(o_tag), 32'd0);
        chk("rsta_rd", o_rd, 32'd0);
        i_reset = 1'b0;
        i_tag = '0;
        #1 chk("rsta_idle_stall", 32'(o_stall), 32'd0);
        i_bus_ready = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(negedge i_clock);
        i_bus_ready = 1'b0;
        chk("rsta_late_rd", o_rd, 32'd0);
        chk("rsta_late_tag", 32'(o_tag), 32'd0);
        chk("rsta_late_inst", 32'(o_inst_rd), 32'd0);
        chk("rsta_late_req", 32'(o_bus_request), 32'd0);
        tb_tag = '0;
        model_rd = '0;
        run_vec(200, vt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_memory.md
CPU_MEMORY -- requirements
Module: CPU_Memory

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: i_reset, i_clock, with all state changing only on posedge i_clock.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_stall  in  1  downstream (writeback) cannot accept; blocks acceptance only
- i_tag  in  `TAG_SIZE  request tag from execute; differs from o_tag means new request
- i_inst_rd  in  5  destination register index
- i_rd  in  32  execute result, passed through for non-load
- i_mem_read / i_mem_write  in  1 / 1  load / store
- i_mem_width  in  3  1=byte, 2=half, 4=word
- i_mem_signed  in  1  sign-extend load
- i_mem_address  in  32  byte address
- i_mem_wdata  in  32  store data, LSB-aligned
- o_bus_request  out  1  bus transaction active
- o_bus_rw  out  1  1=write, 0=read
- o_bus_address  out  32  word address, {addr[31:2],2'b00}
- o_bus_byte_enable  out  4  lane enables
- o_bus_wdata  out  32  lane-shifted store data
- i_bus_ready  in  1  transaction complete; read data valid this cycle
- i_bus_rdata  in  32  read data
- o_tag  out  `TAG_SIZE  tag of last completed request
- o_inst_rd  out  5  destination register (0 for store/fault)
- o_rd  out  32  result
- o_fault  out  1  last completed request was misaligned
- o_stall  out  1  upstream must hold inputs

Function
REQ-003 SHALL define request = !i_stall && (i_tag != o_tag) && state==IDLE.
REQ-004 SHALL implement FSM states IDLE, ACCESS; reset to IDLE.
REQ-005 Non-memory request in IDLE: next edge latch o_inst_rd=i_inst_rd, o_rd=i_rd, o_fault=0, o_tag=i_tag; stay IDLE; latency 1 cycle.
REQ-006 Misaligned (width 2 and addr[0]=1, or width 4 and addr[1:0]!=0): no bus access; next edge o_fault=1, o_inst_rd=0, o_tag=i_tag.
REQ-007 Aligned memory request: next edge enter ACCESS, drive o_bus_request=1, rw, address, byte enable, wdata.
REQ-008 Byte enable: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; wdata replicated/shifted to selected lanes by addr[1:0]*8.
REQ-009 In ACCESS, bus outputs SHALL stay stable until i_bus_ready sampled high; i_stall SHALL NOT abort or pause an ACCESS.
REQ-010 On i_bus_ready in ACCESS: next edge o_bus_request=0, state IDLE, o_tag=i_tag; load: o_rd = selected lane(s) shifted to LSB, zero- or sign-extended per i_mem_signed, o_inst_rd=i_inst_rd; store: o_inst_rd=0, o_rd unchanged.
REQ-011 i_bus_ready outside ACCESS SHALL be ignored.
REQ-012 o_stall SHALL be combinational: 1 when state==ACCESS, or when in IDLE with i_tag!=o_tag and an aligned memory op; else 0.
REQ-013 i_tag==o_tag SHALL cause no state change regardless of other inputs.
REQ-014 Tag compare SHALL be pure inequality so wrap-around of the tag value needs no special handling.
REQ-015 Width encodings other than 1/2/4 SHALL be treated as word.

Reset
REQ-016 On i_reset: state=IDLE, o_tag=0, o_inst_rd=0, o_rd=0, o_fault=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_byte_enable=0, o_bus_wdata=0.
REQ-017 Reset during ACCESS SHALL drop o_bus_request at that edge and discard any pending read data.

Verification
REQ-018 Non-mem: tag 0->1, i_rd=0x1234, rd=5 -> next cycle o_tag=1, o_rd=0x1234, o_inst_rd=5, o_bus_request never high.
REQ-019 Signed byte load addr 0x103, rdata 0x80xxxxxx, ready after 3 cycles -> byte_enable=4'b1000, o_bus_address=0x100, o_rd=0xFFFFFF80, o_stall high until completion edge.
REQ-020 Half store addr 0x202, wdata 0xABCD -> rw=1, byte_enable=4'b1100, o_bus_wdata[31:16]=0xABCD, o_inst_rd=0 on completion.
REQ-021 Word load addr 0x301 -> no bus request, o_fault=1, o_inst_rd=0, o_tag updated next cycle.
REQ-022 New tag with i_stall=1 for 4 cycles -> no acceptance; accepted 1 cycle after i_stall falls; i_stall raised during ACCESS does not drop o_bus_request.
REQ-023 i_reset asserted in ACCESS -> next cycle o_bus_request=0, o_tag=0, state IDLE; late i_bus_ready ignored.
